// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if
// Bundle of signals between the multicycle control unit and the datapath.
//   Instr      : IR bits [25:14] {Cond, Op[1:0], Funct[4:0], Rd[3:0]}
//   ALUFlags   : {N,Z,C,V} from the ALU for the current cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite : enables / address select
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl      : datapath mux selects
//   ImmSrc, RegSrc                               : decode-derived selects
//   Flags      : stored {N,Z,C,V}
//   Illegal    : one-cycle pulse in DECODE for Op==11
// The master modport is the control unit; the slave modport is the datapath.
interface mc_control_fsm_if;
    logic [11:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [3:0]  Flags;
    logic        Illegal;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, Illegal
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Flags, Illegal
    );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm
// Multicycle control unit: sequences one instruction over 2-5 cycles so the
// memory, ALU and PC adder can be shared, keeps the condition flags, and
// gates every architectural write with the instruction's condition.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; returns to FETCH with Flags=0000
//   bus   : mc_control_fsm_if.master (IR fields, ALU flags, all selects/enables)
module mc_control_fsm (
    input  logic               clk,
    input  logic               reset,
    mc_control_fsm_if.master   bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } stateT;

    // Per-state control word; write requests are held here ungated and the
    // condition/reset gating is applied on the way out.
    typedef struct packed {
        logic       pcWriteAlways;
        logic       pcWriteCond;
        logic       adrSrc;
        logic       memWriteReq;
        logic       irWrite;
        logic       regWriteReq;
        logic [1:0] resultSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluControl;
    } ctlT;

    stateT      state;
    ctlT        ctl;
    logic [3:0] flags;

    logic       condBit;
    logic [1:0] op;
    logic       iBit;
    logic       cmpBit;
    logic [1:0] aluOpBits;
    logic       sBit;
    logic       condEx;
    logic       flagUpdate;
    logic       unusedRd;

    assign condBit   = bus.Instr[11];
    assign op        = bus.Instr[10:9];
    assign iBit      = bus.Instr[8];
    assign cmpBit    = bus.Instr[7];
    assign aluOpBits = bus.Instr[6:5];
    assign sBit      = bus.Instr[4];

    // Rd travels with the IR field bundle but the control unit never looks at it.
    assign unusedRd  = ^bus.Instr[3:0];

    // Condition comes from the stored flags only, so a flag-setting
    // instruction sees its own new Z in the writeback cycle.
    assign condEx     = condBit | flags[2];
    assign flagUpdate = ((state == EXECR) || (state == EXECI)) && condEx && (sBit | cmpBit);

    // Next state from the current state and the IR fields that steer it.
    function automatic stateT nextStateOf(input stateT s, input logic [1:0] o,
                                          input logic imm, input logic load);
        stateT n;
        case (s)
            FETCH:  n = DECODE;
            DECODE: begin
                case (o)
                    2'b00:   n = imm ? EXECI : EXECR;
                    2'b01:   n = MEMADR;
                    2'b10:   n = BRANCH;
                    default: n = FETCH;
                endcase
            end
            MEMADR: n = load ? MEMRD : MEMWR;
            MEMRD:  n = MEMWB;
            EXECR:  n = ALUWB;
            EXECI:  n = ALUWB;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    // Control word for a state; f carries Funct[3:1] (compare bit and ALU op),
    // which is valid whenever a DP state is being entered.
    function automatic ctlT outputsFor(input stateT s, input logic [3:1] f);
        ctlT c;
        c = '0;
        case (s)
            FETCH: begin
                c.pcWriteAlways = 1'b1;
                c.irWrite       = 1'b1;
                c.aluSrcA       = 1'b1;
                c.aluSrcB       = 2'b10;
                c.resultSrc     = 2'b10;
            end
            DECODE: begin
                c.aluSrcA   = 1'b1;
                c.aluSrcB   = 2'b10;
                c.resultSrc = 2'b10;
            end
            MEMADR: begin
                c.aluSrcB = 2'b01;
            end
            MEMRD: begin
                c.adrSrc = 1'b1;
            end
            MEMWB: begin
                c.resultSrc   = 2'b01;
                c.regWriteReq = 1'b1;
            end
            MEMWR: begin
                c.adrSrc      = 1'b1;
                c.memWriteReq = 1'b1;
            end
            EXECR: begin
                c.aluControl = f[2:1];
            end
            EXECI: begin
                c.aluSrcB    = 2'b01;
                c.aluControl = f[2:1];
            end
            ALUWB: begin
                c.regWriteReq = ~f[3];
            end
            BRANCH: begin
                c.aluSrcB     = 2'b01;
                c.resultSrc   = 2'b10;
                c.pcWriteCond = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // State, registered control word and condition flags. The control word
    // is computed for the state being entered so it is valid for the whole
    // cycle. C and V only follow the ALU for ADD/SUB (ALUControl[1]==0).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            ctl   <= outputsFor(FETCH, 3'b000);
            flags <= 4'b0000;
        end else begin
            state <= nextStateOf(state, op, iBit, sBit);
            ctl   <= outputsFor(nextStateOf(state, op, iBit, sBit), {cmpBit, aluOpBits});
            if (flagUpdate) begin
                flags[3:2] <= bus.ALUFlags[3:2];
                if (!ctl.aluControl[1]) begin
                    flags[1:0] <= bus.ALUFlags[1:0];
                end
            end
        end
    end

    // Write enables are qualified by the condition and held off while reset
    // is high so nothing half-written escapes an aborted instruction.
    assign bus.PCWrite    = ~reset & (ctl.pcWriteAlways | (ctl.pcWriteCond & condEx));
    assign bus.IRWrite    = ~reset & ctl.irWrite;
    assign bus.RegWrite   = ~reset & ctl.regWriteReq & condEx;
    assign bus.MemWrite   = ~reset & ctl.memWriteReq & condEx;
    assign bus.AdrSrc     = ctl.adrSrc;
    assign bus.ResultSrc  = ctl.resultSrc;
    assign bus.ALUSrcA    = ctl.aluSrcA;
    assign bus.ALUSrcB    = ctl.aluSrcB;
    assign bus.ALUControl = ctl.aluControl;
    assign bus.ImmSrc     = op;
    assign bus.RegSrc     = {op == 2'b01, op == 2'b10};
    assign bus.Flags      = flags;
    assign bus.Illegal    = (state == DECODE) && (op == 2'b11);

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm
// Directed scoreboard bench for mc_control_fsm. Each stimulus cycle pushes the
// hand-computed expected output vector; a monitor pops and compares on the
// falling edge.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] instr;
    logic [3:0]  aluFlags;
    logic [3:0]  curFlags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [20:0] exp;
    } expT;

    expT expQ[$];

    mc_control_fsm_if bus();

    assign bus.Instr    = instr;
    assign bus.ALUFlags = aluFlags;

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Output vector layout shared by expected and observed values.
    function automatic logic [20:0] dutVec();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                bus.ImmSrc, bus.RegSrc, bus.Flags, bus.Illegal};
    endfunction

    // ImmSrc/RegSrc follow the Op currently sitting in the bench's IR.
    function automatic logic [20:0] mkExp(input logic pcw, input logic adr, input logic mw,
                                          input logic irw, input logic rw, input logic [1:0] rs,
                                          input logic asa, input logic [1:0] asb,
                                          input logic [1:0] ac, input logic [3:0] fl,
                                          input logic ill);
        logic [1:0] o;
        o = instr[10:9];
        return {pcw, adr, mw, irw, rw, rs, asa, asb, ac, o,
                (o == 2'b01), (o == 2'b10), fl, ill};
    endfunction

    // Queue this cycle's expectation, then advance to just after the next edge.
    task automatic applyStimulus(input string name, input logic [20:0] e);
        expT item;
        item.name = name;
        item.exp  = e;
        expQ.push_back(item);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [20:0] e);
        logic [20:0] got;
        got = dutVec();
        checks++;
        if (got !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, e);
        end
    endtask

    // Monitor: compare whatever expectation is pending for this cycle.
    initial begin
        expT item;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                item = expQ.pop_front();
                checkOutput(item.name, item.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic fetchCyc(input string name);
        applyStimulus({name, ":fetch"},
                      mkExp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, curFlags, 1'b0));
    endtask

    task automatic decodeCyc(input string name, input logic ill);
        applyStimulus({name, ":decode"},
                      mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, curFlags, ill));
    endtask

    task automatic runDp(input string name, input logic [11:0] ins, input logic [3:0] af,
                         input logic [1:0] expAsb, input logic [1:0] expAc,
                         input logic expRw, input logic [3:0] newFlags);
        fetchCyc(name);
        instr    = ins;
        aluFlags = af;
        decodeCyc(name, 1'b0);
        applyStimulus({name, ":exec"},
                      mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, expAsb, expAc, curFlags, 1'b0));
        curFlags = newFlags;
        applyStimulus({name, ":aluwb"},
                      mkExp(1'b0, 1'b0, 1'b0, 1'b0, expRw, 2'b00, 1'b0, 2'b00, 2'b00, curFlags, 1'b0));
    endtask

    task automatic runMem(input string name, input logic [11:0] ins, input logic expWr);
        fetchCyc(name);
        instr = ins;
        decodeCyc(name, 1'b0);
        applyStimulus({name, ":memadr"},
                      mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00, curFlags, 1'b0));
        if (ins[4]) begin
            applyStimulus({name, ":memrd"},
                          mkExp(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, curFlags, 1'b0));
            applyStimulus({name, ":memwb"},
                          mkExp(1'b0, 1'b0, 1'b0, 1'b0, expWr, 2'b01, 1'b0, 2'b00, 2'b00, curFlags, 1'b0));
        end else begin
            applyStimulus({name, ":memwr"},
                          mkExp(1'b0, 1'b1, expWr, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, curFlags, 1'b0));
        end
    endtask

    task automatic runBr(input string name, input logic [11:0] ins, input logic expPcw);
        fetchCyc(name);
        instr = ins;
        decodeCyc(name, 1'b0);
        applyStimulus({name, ":branch"},
                      mkExp(expPcw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00, curFlags, 1'b0));
    endtask

    task automatic runIll(input string name, input logic [11:0] ins);
        fetchCyc(name);
        instr = ins;
        decodeCyc(name, 1'b1);
    endtask

    // Directed program; instruction encoding is {Cond, Op, Funct, Rd}.
    initial begin
        reset    = 1'b1;
        instr    = 12'h000;
        aluFlags = 4'b0000;
        curFlags = 4'b0000;

        @(posedge clk);
        #1;
        applyStimulus("reset",
                      mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0000, 1'b0));
        reset = 1'b0;

        runDp("addi",  {1'b1, 2'b00, 5'b10001, 4'h1}, 4'b0100, 2'b01, 2'b00, 1'b1, 4'b0100);
        runDp("cmpN",  {1'b1, 2'b00, 5'b01010, 4'h2}, 4'b1000, 2'b00, 2'b01, 1'b0, 4'b1000);
        runBr("bNo",   {1'b0, 2'b10, 5'b00000, 4'h0}, 1'b0);
        runDp("cmpZ",  {1'b1, 2'b00, 5'b01010, 4'h2}, 4'b0100, 2'b00, 2'b01, 1'b0, 4'b0100);
        runBr("bYes",  {1'b0, 2'b10, 5'b00000, 4'h0}, 1'b1);
        runMem("ldr",  {1'b1, 2'b01, 5'b00001, 4'h3}, 1'b1);
        runDp("cmp0",  {1'b1, 2'b00, 5'b01010, 4'h2}, 4'b0000, 2'b00, 2'b01, 1'b0, 4'b0000);
        runMem("strNo",{1'b0, 2'b01, 5'b00000, 4'h4}, 1'b0);
        runIll("ill",  {1'b1, 2'b11, 5'b00000, 4'h0});
        runDp("addCV", {1'b1, 2'b00, 5'b00001, 4'h5}, 4'b0011, 2'b00, 2'b00, 1'b1, 4'b0011);
        runDp("andS",  {1'b1, 2'b00, 5'b00101, 4'h6}, 4'b1000, 2'b00, 2'b10, 1'b1, 4'b1011);
        runDp("addNo", {1'b0, 2'b00, 5'b10001, 4'h7}, 4'b0100, 2'b01, 2'b00, 1'b0, 4'b1011);
        runMem("str",  {1'b1, 2'b01, 5'b00000, 4'h8}, 1'b1);

        // Abort an instruction in EXECR with reset, then resume fetching.
        fetchCyc("rstMid");
        instr    = {1'b1, 2'b00, 5'b00001, 4'h9};
        aluFlags = 4'b0100;
        decodeCyc("rstMid", 1'b0);
        reset    = 1'b1;
        curFlags = 4'b0000;
        #1;
        applyStimulus("rstMid:held",
                      mkExp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00, 4'b0000, 1'b0));
        reset = 1'b0;

        runMem("ldrNo",{1'b0, 2'b01, 5'b00001, 4'hA}, 1'b0);

        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
